// File: rtl/mac_job_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mac_job_arbiter
//  Purpose  : Round-robin arbiter that hands MAC jobs from two requesters to
//             a single MAC engine. Streams the winner's operand pairs onto
//             the engine, waits for the engine sum and returns it as a result.
//  Ports    : clk, nrst (synchronous, active-low)
//             req{0,1}_*  job request (valid/ready, mode, batch, sx, sy)
//             op{0,1}_*   operand stream (valid/ready, act, wgt)
//             eng_*       engine control, operand pair and sum return
//             res_*       result (valid/ready, sum, requester id, error)
//  Options  : MAC_JOB_ARBITER_WDT_EN adds a 10-bit DRAIN watchdog that
//             aborts the job with res_err=1 after 1023 DRAIN cycles.
//  Revision : 1.0  initial release
// ============================================================================
module mac_job_arbiter (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_mode,
    input  logic [7:0]  req0_batch,
    input  logic        req0_sx,
    input  logic        req0_sy,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_mode,
    input  logic [7:0]  req1_batch,
    input  logic        req1_sx,
    input  logic        req1_sy,
    input  logic        op0_valid,
    output logic        op0_ready,
    input  logic [7:0]  op0_act,
    input  logic [7:0]  op0_wgt,
    input  logic        op1_valid,
    output logic        op1_ready,
    input  logic [7:0]  op1_act,
    input  logic [7:0]  op1_wgt,
    output logic [7:0]  eng_activations,
    output logic [7:0]  eng_weights,
    output logic [3:0]  eng_mode,
    output logic        eng_sx,
    output logic        eng_sy,
    output logic [7:0]  eng_batch_size,
    output logic        eng_en,
    output logic        eng_ready,
    input  logic        eng_valid,
    input  logic [19:0] eng_sum,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [19:0] res_sum,
    output logic        res_id,
    output logic        res_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_prio;      // requester that wins a tie
    logic        r_id;        // requester owning the current job
    logic [7:0]  r_cnt;       // STREAM cycles still to go
    logic        r_underrun;  // sticky: a STREAM cycle had no operand
`ifdef MAC_JOB_ARBITER_WDT_EN
    logic [9:0]  r_wdt;
`endif

    logic        w_grant_valid;
    logic        w_grant_id;
    logic [3:0]  w_sel_mode;
    logic [7:0]  w_sel_batch;
    logic        w_sel_sx;
    logic        w_sel_sy;
    logic        w_op_valid;
    logic [7:0]  w_op_act;
    logic [7:0]  w_op_wgt;

    // Grants are only offered while idle with no result outstanding.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = 1'b0;
        if (r_state == ST_IDLE && !res_valid) begin
            if (req0_valid && req1_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = r_prio;
            end else if (req0_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = 1'b0;
            end else if (req1_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = 1'b1;
            end
        end
    end

    assign req0_ready  = w_grant_valid && !w_grant_id;
    assign req1_ready  = w_grant_valid &&  w_grant_id;
    assign op0_ready   = (r_state == ST_STREAM) && !r_id;
    assign op1_ready   = (r_state == ST_STREAM) &&  r_id;

    assign w_sel_mode  = w_grant_id ? req1_mode  : req0_mode;
    assign w_sel_batch = w_grant_id ? req1_batch : req0_batch;
    assign w_sel_sx    = w_grant_id ? req1_sx    : req0_sx;
    assign w_sel_sy    = w_grant_id ? req1_sy    : req0_sy;
    assign w_op_valid  = r_id ? op1_valid : op0_valid;
    assign w_op_act    = r_id ? op1_act   : op0_act;
    assign w_op_wgt    = r_id ? op1_wgt   : op0_wgt;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state         <= ST_IDLE;
            r_prio          <= 1'b0;
            r_id            <= 1'b0;
            r_cnt           <= 8'd0;
            r_underrun      <= 1'b0;
            eng_activations <= 8'd0;
            eng_weights     <= 8'd0;
            eng_mode        <= 4'd0;
            eng_sx          <= 1'b0;
            eng_sy          <= 1'b0;
            eng_batch_size  <= 8'd0;
            eng_en          <= 1'b0;
            eng_ready       <= 1'b0;
            res_valid       <= 1'b0;
            res_sum         <= 20'd0;
            res_id          <= 1'b0;
            res_err         <= 1'b0;
`ifdef MAC_JOB_ARBITER_WDT_EN
            r_wdt           <= 10'd0;
`endif
        end else begin
            // The operand pair register only carries data for one cycle
            // after each STREAM cycle; otherwise it rests at zero.
            eng_activations <= 8'd0;
            eng_weights     <= 8'd0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_id           <= w_grant_id;
                        r_prio         <= ~w_grant_id;
                        r_cnt          <= w_sel_batch;
                        eng_mode       <= w_sel_mode;
                        eng_sx         <= w_sel_sx;
                        eng_sy         <= w_sel_sy;
                        eng_batch_size <= w_sel_batch;
                        if (w_sel_batch == 8'd0) begin
                            // Empty job: no engine work, flagged as an error.
                            r_state   <= ST_RESP;
                            res_valid <= 1'b1;
                            res_sum   <= 20'd0;
                            res_err   <= 1'b1;
                            res_id    <= w_grant_id;
                        end else begin
                            r_state <= ST_STREAM;
                            eng_en  <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    eng_activations <= w_op_valid ? w_op_act : 8'd0;
                    eng_weights     <= w_op_valid ? w_op_wgt : 8'd0;
                    if (!w_op_valid) begin
                        r_underrun <= 1'b1;
                    end
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        r_state   <= ST_DRAIN;
                        eng_ready <= 1'b1;
`ifdef MAC_JOB_ARBITER_WDT_EN
                        r_wdt     <= 10'd0;
`endif
                    end
                end
                ST_DRAIN: begin
                    if (eng_valid && eng_ready) begin
                        r_state   <= ST_RESP;
                        res_valid <= 1'b1;
                        res_sum   <= eng_sum;
                        res_id    <= r_id;
                        res_err   <= r_underrun;
                        eng_en    <= 1'b0;
                        eng_ready <= 1'b0;
                    end
`ifdef MAC_JOB_ARBITER_WDT_EN
                    // 1022 marks the 1023rd DRAIN cycle without a sum.
                    else if (r_wdt == 10'd1022) begin
                        r_state   <= ST_RESP;
                        res_valid <= 1'b1;
                        res_sum   <= 20'd0;
                        res_id    <= r_id;
                        res_err   <= 1'b1;
                        eng_en    <= 1'b0;
                        eng_ready <= 1'b0;
                        r_wdt     <= 10'd0;
                    end else begin
                        r_wdt <= r_wdt + 10'd1;
                    end
`endif
                end
                ST_RESP: begin
                    if (res_ready) begin
                        // Job configuration is released together with the result.
                        r_state        <= ST_IDLE;
                        res_valid      <= 1'b0;
                        r_underrun     <= 1'b0;
                        eng_mode       <= 4'd0;
                        eng_sx         <= 1'b0;
                        eng_sy         <= 1'b0;
                        eng_batch_size <= 8'd0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_job_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mac_job_arbiter
//  Purpose  : Self-checking bench for mac_job_arbiter. A job-timeline model
//             predicts every output each cycle; directed jobs add literal
//             expectations. Define MAC_JOB_ARBITER_WDT_EN to cover the
//             DRAIN watchdog as well.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mac_job_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic        req0_valid, req0_ready, req0_sx, req0_sy;
    logic [3:0]  req0_mode;
    logic [7:0]  req0_batch;
    logic        req1_valid, req1_ready, req1_sx, req1_sy;
    logic [3:0]  req1_mode;
    logic [7:0]  req1_batch;
    logic        op0_valid, op0_ready, op1_valid, op1_ready;
    logic [7:0]  op0_act, op0_wgt, op1_act, op1_wgt;
    logic [7:0]  eng_activations, eng_weights, eng_batch_size;
    logic [3:0]  eng_mode;
    logic        eng_sx, eng_sy, eng_en, eng_ready, eng_valid;
    logic [19:0] eng_sum, res_sum;
    logic        res_valid, res_ready, res_id, res_err;

    mac_job_arbiter dut (
        .clk(clk), .nrst(nrst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
        .req0_batch(req0_batch), .req0_sx(req0_sx), .req0_sy(req0_sy),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
        .req1_batch(req1_batch), .req1_sx(req1_sx), .req1_sy(req1_sy),
        .op0_valid(op0_valid), .op0_ready(op0_ready), .op0_act(op0_act), .op0_wgt(op0_wgt),
        .op1_valid(op1_valid), .op1_ready(op1_ready), .op1_act(op1_act), .op1_wgt(op1_wgt),
        .eng_activations(eng_activations), .eng_weights(eng_weights),
        .eng_mode(eng_mode), .eng_sx(eng_sx), .eng_sy(eng_sy),
        .eng_batch_size(eng_batch_size), .eng_en(eng_en), .eng_ready(eng_ready),
        .eng_valid(eng_valid), .eng_sum(eng_sum),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_id(res_id), .res_err(res_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- job-timeline model ----------------
    bit          m_live, m_clean, m_job, m_done, m_under, m_prio;
    int          m_k, m_b;          // m_k = cycle index since acceptance (1 = first)
    bit          m_id, m_sx, m_sy;
    logic [3:0]  m_mode;
    bit          m_res, m_rid, m_rerr;
    logic [19:0] m_rsum;
    logic [7:0]  m_pa, m_pw;
    bit          mv_st, mv_dr, mv_ov;
    int          mv_w;

    function automatic bit f_stream();
        return m_job && !m_done && m_k >= 1 && m_k <= m_b;
    endfunction
    function automatic bit f_drain();
        return m_job && !m_done && m_k > m_b;
    endfunction
    function automatic int f_winner();
        if (m_job) return -1;
        if (req0_valid && req1_valid) return m_prio ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!nrst) begin
                m_live = 1; m_clean = 1; m_job = 0; m_done = 0; m_under = 0;
                m_prio = 0; m_k = 0; m_b = 0; m_res = 0; m_pa = 0; m_pw = 0;
            end else if (m_live) begin
                mv_st = f_stream();
                mv_dr = f_drain();
                mv_w  = f_winner();
                if (mv_st) begin
                    mv_ov = m_id ? op1_valid : op0_valid;
                    m_pa  = mv_ov ? (m_id ? op1_act : op0_act) : 8'd0;
                    m_pw  = mv_ov ? (m_id ? op1_wgt : op0_wgt) : 8'd0;
                    if (!mv_ov) m_under = 1;
                end else begin
                    m_pa = 0; m_pw = 0;
                end
                if (mv_w >= 0) begin
                    m_job = 1; m_k = 1; m_done = 0; m_clean = 0;
                    m_id   = (mv_w == 1);
                    m_b    = (mv_w == 1) ? int'(req1_batch) : int'(req0_batch);
                    m_mode = (mv_w == 1) ? req1_mode : req0_mode;
                    m_sx   = (mv_w == 1) ? req1_sx : req0_sx;
                    m_sy   = (mv_w == 1) ? req1_sy : req0_sy;
                    m_prio = (mv_w == 0);
                    if (m_b == 0) begin
                        m_done = 1; m_res = 1; m_rsum = 0; m_rerr = 1; m_rid = m_id;
                    end
                end else if (m_job) begin
                    if (m_res) begin
                        if (res_ready) begin m_res = 0; m_job = 0; m_under = 0; end
                    end else if (mv_dr && eng_valid) begin
                        m_res = 1; m_done = 1; m_rsum = eng_sum; m_rid = m_id; m_rerr = m_under;
                    end
`ifdef MAC_JOB_ARBITER_WDT_EN
                    else if (mv_dr && (m_k - m_b) == 1023) begin
                        m_res = 1; m_done = 1; m_rsum = 0; m_rid = m_id; m_rerr = 1;
                    end
`endif
                    m_k++;
                end
            end
        end
    end

    // ---------------- per-cycle compare + monitors ----------------
    int cnt_op0, cnt_op1, cnt_en, cnt_engready, cnt_res;
    int grant_log[$];
    int resid_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                chk("req0_ready", req0_ready, f_winner() == 0);
                chk("req1_ready", req1_ready, f_winner() == 1);
                chk("op0_ready", op0_ready, f_stream() && !m_id);
                chk("op1_ready", op1_ready, f_stream() && m_id);
                chk("eng_en", eng_en, f_stream() || f_drain());
                chk("eng_ready", eng_ready, f_drain());
                chk("eng_activations", eng_activations, m_pa);
                chk("eng_weights", eng_weights, m_pw);
                chk("res_valid", res_valid, m_res);
                if (m_res) begin
                    chk("res_sum", res_sum, m_rsum);
                    chk("res_id", res_id, m_rid);
                    chk("res_err", res_err, m_rerr);
                end
                if (f_stream() || f_drain()) begin
                    chk("eng_mode", eng_mode, m_mode);
                    chk("eng_batch_size", eng_batch_size, m_b);
                    chk("eng_sx", eng_sx, m_sx);
                    chk("eng_sy", eng_sy, m_sy);
                end
                if (m_clean) begin
                    chk("clean_cfg", {eng_mode, eng_batch_size, eng_sx, eng_sy}, 0);
                    chk("clean_res", {res_sum, res_id, res_err}, 0);
                end
                if (op0_ready) cnt_op0++;
                if (op1_ready) cnt_op1++;
                if (eng_en) cnt_en++;
                if (eng_ready) cnt_engready++;
                if (res_valid) cnt_res++;
                if (req0_ready && req0_valid) grant_log.push_back(0);
                if (req1_ready && req1_valid) grant_log.push_back(1);
                if (res_valid && res_ready) resid_log.push_back(int'(res_id));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        nrst = 0; req0_valid = 0; req1_valid = 0; op0_valid = 0; op1_valid = 0;
        repeat (2) @(posedge clk);
        #1 nrst = 1;
    endtask

    task automatic raise_req(input bit who, input logic [3:0] mode, input logic [7:0] batch,
                             input bit sx, input bit sy);
        if (!who) begin
            req0_valid = 1; req0_mode = mode; req0_batch = batch; req0_sx = sx; req0_sy = sy;
        end else begin
            req1_valid = 1; req1_mode = mode; req1_batch = batch; req1_sx = sx; req1_sy = sy;
        end
    endtask

    // Returns at the negedge of the cycle in which the grant is offered.
    task automatic wait_grant(input bit who);
        bit ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = who ? (req1_ready && req1_valid) : (req0_ready && req0_valid);
        end
        chk("wait_grant", ok, 1);
    endtask

    task automatic wait_result(input int budget);
        bit ok = 0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            ok = res_valid;
        end
        chk("wait_result", ok, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        nrst = 0;
        req0_valid = 0; req0_mode = 0; req0_batch = 0; req0_sx = 0; req0_sy = 0;
        req1_valid = 0; req1_mode = 0; req1_batch = 0; req1_sx = 0; req1_sy = 0;
        op0_valid = 0; op0_act = 0; op0_wgt = 0; op1_valid = 0; op1_act = 0; op1_wgt = 0;
        eng_valid = 0; eng_sum = 0; res_ready = 1;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_eng_en", eng_en, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_eng_cfg", {eng_mode, eng_batch_size, eng_sx, eng_sy}, 0);

        // Requester 0, batch 4, pairs (1,1)..(4,4), engine sum 30
        @(posedge clk); #1;
        eng_valid = 1; eng_sum = 20'd30;
        raise_req(0, 4'd2, 8'd4, 0, 0);
        wait_grant(0);
        cnt_op0 = 0;
        @(posedge clk); #1;
        req0_valid = 0;
        for (int i = 1; i <= 4; i++) begin
            op0_valid = 1; op0_act = i[7:0]; op0_wgt = i[7:0];
            if (i < 4) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        op0_valid = 0;
        wait_result(20);
        chk("t1_sum", res_sum, 20'd30);
        chk("t1_id", res_id, 0);
        chk("t1_err", res_err, 0);
        chk("t1_op0_ready_cycles", cnt_op0, 4);

        // Both requesters held: three batch=1 jobs alternate 0,1,0
        do_reset();
        eng_valid = 1; eng_sum = 20'd11;
        op0_valid = 1; op0_act = 8'd3; op0_wgt = 8'd4;
        op1_valid = 1; op1_act = 8'd5; op1_wgt = 8'd6;
        grant_log.delete(); resid_log.delete();
        raise_req(0, 4'd2, 8'd1, 0, 0);
        raise_req(1, 4'd2, 8'd1, 1, 1);
        for (int n = 0; n < 100 && grant_log.size() < 3; n++) @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        for (int n = 0; n < 100 && resid_log.size() < 3; n++) @(negedge clk);
        chk("t2_grants", grant_log.size(), 3);
        chk("t2_results", resid_log.size(), 3);
        if (grant_log.size() >= 3) begin
            chk("t2_grant0", grant_log[0], 0);
            chk("t2_grant1", grant_log[1], 1);
            chk("t2_grant2", grant_log[2], 0);
        end
        if (resid_log.size() >= 3) begin
            chk("t2_resid0", resid_log[0], 0);
            chk("t2_resid1", resid_log[1], 1);
            chk("t2_resid2", resid_log[2], 0);
        end
        @(posedge clk); #1;
        op0_valid = 0; op1_valid = 0;

        // Requester 1, batch 3, missing operand on the 2nd STREAM cycle
        eng_sum = 20'h54321;
        raise_req(1, 4'd1, 8'd3, 1, 0);
        wait_grant(1);
        cnt_op1 = 0;
        @(posedge clk); #1;
        req1_valid = 0; op1_valid = 1; op1_act = 8'd5; op1_wgt = 8'd6;
        @(posedge clk); #1;
        op1_valid = 0; op1_act = 8'd7; op1_wgt = 8'd7;
        @(negedge clk);
        chk("t3_pair1_act", eng_activations, 8'd5);
        chk("t3_pair1_wgt", eng_weights, 8'd6);
        @(posedge clk); #1;
        op1_valid = 1; op1_act = 8'd8; op1_wgt = 8'd9;
        @(negedge clk);
        chk("t3_zero_pair", {eng_activations, eng_weights}, 16'd0);
        @(posedge clk); #1;
        op1_valid = 0;
        @(negedge clk);
        chk("t3_pair3", {eng_activations, eng_weights}, {8'd8, 8'd9});
        chk("t3_drain", eng_ready, 1);
        wait_result(20);
        chk("t3_err", res_err, 1);
        chk("t3_id", res_id, 1);
        chk("t3_sum", res_sum, 20'h54321);
        chk("t3_op1_ready_cycles", cnt_op1, 3);

        // Batch 0: straight to a result, engine untouched
        @(posedge clk); #1;
        raise_req(0, 4'd3, 8'd0, 0, 0);
        wait_grant(0);
        cnt_en = 0;
        @(posedge clk); #1;
        req0_valid = 0;
        @(negedge clk);
        chk("t4_res_valid", res_valid, 1);
        chk("t4_sum", res_sum, 0);
        chk("t4_err", res_err, 1);
        chk("t4_eng_en", eng_en, 0);
        chk("t4_eng_en_cycles", cnt_en, 0);

        // Result back-pressure with the other requester waiting
        @(posedge clk); #1;
        res_ready = 0; eng_valid = 1; eng_sum = 20'd77;
        op1_valid = 1; op1_act = 8'd2; op1_wgt = 8'd3;
        raise_req(1, 4'd2, 8'd1, 0, 0);
        wait_grant(1);
        @(posedge clk); #1;
        req1_valid = 0;
        raise_req(0, 4'd4, 8'd0, 0, 0);
        wait_result(20);
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid", res_valid, 1);
            chk("t5_hold_sum", res_sum, 20'd77);
            chk("t5_no_grant", req0_ready, 0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        res_ready = 1;
        @(negedge clk);
        chk("t5_consume_valid", res_valid, 1);
        chk("t5_consume_nogrant", req0_ready, 0);
        @(negedge clk);
        chk("t5_after_valid", res_valid, 0);
        chk("t5_after_grant", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0; op1_valid = 0;
        @(negedge clk);
        chk("t5_next_result", {res_valid, res_id, res_err}, 3'b101);

        // Reset during STREAM abandons the job
        @(posedge clk); #1;
        eng_valid = 0;
        raise_req(0, 4'd2, 8'd5, 1, 1);
        wait_grant(0);
        @(posedge clk); #1;
        req0_valid = 0; op0_valid = 1; op0_act = 8'd9; op0_wgt = 8'd9;
        @(posedge clk); #1;
        @(posedge clk); #1;
        nrst = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_eng_en", eng_en, 0);
        chk("t6_op0_ready", op0_ready, 0);
        chk("t6_pair", {eng_activations, eng_weights}, 16'd0);
        chk("t6_cfg", {eng_mode, eng_batch_size, eng_sx, eng_sy}, 0);
        chk("t6_res", {res_valid, res_sum, res_id, res_err}, 0);
        @(posedge clk); #1;
        nrst = 1; op0_valid = 0;
        cnt_res = 0;
        repeat (10) @(negedge clk);
        chk("t6_no_result", cnt_res, 0);

`ifdef MAC_JOB_ARBITER_WDT_EN
        // Engine never answers: watchdog closes the job after 1023 DRAIN cycles
        @(posedge clk); #1;
        raise_req(1, 4'd2, 8'd1, 0, 0);
        wait_grant(1);
        cnt_engready = 0;
        @(posedge clk); #1;
        req1_valid = 0; op1_valid = 1; op1_act = 8'd1; op1_wgt = 8'd1;
        wait_result(1200);
        chk("wdt_err", res_err, 1);
        chk("wdt_sum", res_sum, 0);
        chk("wdt_drain_cycles", cnt_engready, 1023);
        chk("wdt_eng_en", eng_en, 0);
        @(posedge clk); #1;
        op1_valid = 0;
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_job_arbiter.md
MAC_JOB_ARBITER -- requirements
Module: mac_job_arbiter

Interface
REQ-001 SHALL have ports clk (in, 1, clock) and nrst (in, 1, synchronous active-low reset); reset nrst, synchronous, active-low; clock clk.
REQ-002 SHALL have, for each requester i in {0,1}, the following job-request ports:
- reqi_valid (in, 1): job request.
- reqi_ready (out, 1): job accepted.
- reqi_mode (in, 4): precision mode.
- reqi_batch (in, 8): operand-pair count.
- reqi_sx, reqi_sy (in, 1 each): signedness.
REQ-003 SHALL have, for each requester i, operand ports opi_valid (in, 1), opi_ready (out, 1), opi_act (in, 8) and opi_wgt (in, 8).
REQ-004 SHALL have engine-side ports:
- eng_activations, eng_weights (out, 8 each).
- eng_mode (out, 4); eng_sx, eng_sy (out, 1 each).
- eng_batch_size (out, 8).
- eng_en (out, 1), eng_ready (out, 1).
- eng_valid (in, 1), eng_sum (in, 20).
REQ-005 SHALL have result ports res_valid (out, 1), res_ready (in, 1), res_sum (out, 20), res_id (out, 1, requester index) and res_err (out, 1).

Function
REQ-006 SHALL implement states IDLE, STREAM, DRAIN and RESP.
REQ-007 Arbitration SHALL be round-robin: in IDLE with res_valid low, the winner is the valid requester not granted last; on a tie after reset, requester 0 wins.
REQ-008 reqi_ready SHALL be asserted combinationally only for the IDLE winner; acceptance happens on reqi_valid && reqi_ready.
REQ-009 On acceptance, mode, sx, sy, batch and the requester id SHALL be registered and driven on eng_* from the next cycle until the job ends.
REQ-010 A job with batch != 0 SHALL enter STREAM the cycle after acceptance.
REQ-011 In STREAM:
- eng_en SHALL be 1.
- opi_ready SHALL be 1 for the granted requester only, for exactly batch consecutive cycles.
- A down-counter from batch SHALL decrement each STREAM cycle.
REQ-012 Each STREAM cycle, the granted act/wgt pair SHALL be registered onto eng_activations/eng_weights one cycle later.
REQ-013 If opi_valid is 0 in a STREAM cycle, the arbiter SHALL register a zero pair, still count the cycle, and set a sticky underrun flag.
REQ-014 Outside STREAM, eng_activations and eng_weights SHALL be 0.
REQ-015 When the counter reaches 0, the arbiter SHALL enter DRAIN with eng_en held at 1 and eng_ready at 1.
REQ-016 On eng_valid && eng_ready in DRAIN:
- eng_sum SHALL be captured into res_sum, the id into res_id, and the underrun flag into res_err.
- res_valid SHALL be set and state SHALL go to RESP.
- eng_en and eng_ready SHALL drop the next cycle.
REQ-017 eng_ready SHALL be 0 in all states except DRAIN.
REQ-018 In RESP, res_valid SHALL be held until res_valid && res_ready; then res_valid SHALL clear, the underrun flag SHALL clear, and state SHALL return to IDLE.
REQ-019 No new grant SHALL occur on the same cycle a result is consumed; the earliest next acceptance is the cycle after.
REQ-020 A batch==0 job SHALL skip the engine and go directly to RESP with res_sum=0 and res_err=1.
REQ-021 Simultaneous reqi_valid from both requesters SHALL grant exactly one; the loser's reqi_ready SHALL stay 0.
REQ-022 eng_valid outside DRAIN SHALL be ignored.

Reset
REQ-023 On nrst=0 at a clock edge, the following SHALL apply:
- state SHALL be IDLE and the round-robin pointer SHALL favour requester 0.
- The counter and underrun flag SHALL be 0.
- eng_en, eng_ready, res_valid and res_err SHALL be 0.
- res_sum, res_id, eng_activations, eng_weights, eng_mode, eng_batch_size, eng_sx and eng_sy SHALL be 0.
REQ-024 Reset mid-job SHALL abandon the job with no result emitted; eng_en SHALL be 0 the cycle after reset is sampled.

Configuration
REQ-025 With macro MAC_JOB_ARBITER_WDT_EN defined, the arbiter SHALL include a 10-bit DRAIN watchdog.
- The watchdog SHALL clear on DRAIN entry.
- If 1023 DRAIN cycles pass without eng_valid, the arbiter SHALL drop eng_en, enter RESP with res_sum=0 and res_err=1, and return the watchdog to 0.
REQ-026 Without MAC_JOB_ARBITER_WDT_EN, DRAIN SHALL wait indefinitely and no watchdog logic SHALL exist.

Verification
REQ-027 Requester 0 job: mode=2 (8bx8b), batch=4, pairs (1,1),(2,2),(3,3),(4,4); engine returns eng_sum=30. Expected: op0_ready high for exactly 4 cycles, then res_valid with res_sum=30, res_id=0, res_err=0.
REQ-028 Both reqi_valid held high for 3 back-to-back batch=1 jobs. Expected: grants in order 0,1,0 and res_id sequence 0,1,0.
REQ-029 Batch=3 with op1_valid low on the 2nd STREAM cycle. Expected: a zero pair on the engine that cycle, STREAM still ends after 3 cycles, res_err=1.
REQ-030 Batch=0 request. Expected: no eng_en pulse; res_valid the cycle after acceptance with res_sum=0 and res_err=1.
REQ-031 res_ready held 0 for 5 cycles with the other requester pending. Expected: res_valid stable, no reqi_ready, grant the cycle after consumption.
REQ-032 nrst=0 asserted mid-STREAM. Expected: all outputs 0 the next cycle, no result emitted; with the WDT macro defined and eng_valid never asserted, res_err=1 after 1023 DRAIN cycles.
